// File: rtl/x7seg_defs.sv
// Shared seven-segment definitions: the hex glyph table, the dp bit position and the default polarities.
// Latency: none (constants only).
// Backpressure: not applicable.
package x7seg_defs;

    // Bit positions in the 8-bit segment bus: bit7 = dp, bit6..0 = g,f,e,d,c,b,a.
    localparam int SEG_DP = 7;

    // Active-high glyphs for nibbles 0..F. Entry 0 is the rightmost byte; bit7 (dp) is always clear here.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    // Default pin polarities: 1 = active-low.
    localparam bit SEG_ACT_LOW_DEF = 1'b1;
    localparam bit AN_ACT_LOW_DEF  = 1'b1;

endpackage

// File: rtl/x7seg_hexdec.sv
// Hex nibble plus decimal point to an active-high 8-bit segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: i_nib  - hex digit 0..F
//        i_dp   - decimal point, 1 = lit
//        o_seg  - {dp, g, f, e, d, c, b, a}, active-high
module x7seg_hexdec
    import x7seg_defs::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg         = SEG_HEX[i_nib];
        o_seg[SEG_DP] = i_dp;
    end

endmodule

// File: rtl/x7seg_scan.sv
// Multiplexed NDIG-digit seven-segment driver with shadow capture, digit mask and leading-zero blanking.
// Latency: a load at one edge reaches the pins on the next edge, except when that edge is a slot tick.
// Backpressure: none; load may be held high every cycle and simply tracks the inputs.
// Ports: clk, rst (sync, active-high)
//        load          - capture data/dp/en_mask into the shadow
//        data, dp      - nibble and decimal point per digit, digit 0 least significant
//        en_mask       - 1 = digit enabled
//        blank_lz      - live leading-zero blanking enable
//        an, a_to_g    - registered anode select and segment bus, polarity applied
module x7seg_scan
    import x7seg_defs::*;
#(
    parameter int NDIG        = 4,
    parameter int DIV_W       = 16,
    parameter bit SEG_ACT_LOW = SEG_ACT_LOW_DEF,
    parameter bit AN_ACT_LOW  = AN_ACT_LOW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   en_mask,
    input  logic              blank_lz,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        a_to_g
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [7:0]      SEG_OFF = {8{SEG_ACT_LOW}};
    localparam logic [NDIG-1:0] AN_OFF  = {NDIG{AN_ACT_LOW}};

    logic [DIV_W-1:0]  r_presc;
    logic [IDX_W-1:0]  r_idx;
    logic [4*NDIG-1:0] r_sh_data;
    logic [NDIG-1:0]   r_sh_dp;
    logic [NDIG-1:0]   r_sh_mask;
    logic [NDIG-1:0]   r_an;
    logic [7:0]        r_seg;

    logic              w_tick;
    logic [NDIG-1:0]   w_lz;
    logic              w_all_zero;
    logic [3:0]        w_nib;
    logic              w_dp;
    logic              w_mask;
    logic              w_lz_sel;
    logic [NDIG-1:0]   w_onehot;
    logic              w_dark;
    logic [7:0]        w_pat;

    assign w_tick = &r_presc;

    // Leading-zero flags: walk down from the top digit; a digit stays a leading zero
    // only while every digit at or above it has a zero nibble and an unlit dp.
    // Digit 0 is never blanked so an all-zero word still shows "0".
    always_comb begin
        w_lz       = '0;
        w_all_zero = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_all_zero = w_all_zero && (r_sh_data[4*i +: 4] == 4'h0) && !r_sh_dp[i];
            w_lz[i]    = (i > 0) && w_all_zero;
        end
    end

    // Select the current digit with constant indices so non-power-of-two NDIG stays safe.
    always_comb begin
        w_nib    = 4'h0;
        w_dp     = 1'b0;
        w_mask   = 1'b0;
        w_lz_sel = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_sh_data[4*i +: 4];
                w_dp        = r_sh_dp[i];
                w_mask      = r_sh_mask[i];
                w_lz_sel    = w_lz[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_dark = !w_mask || (blank_lz && w_lz_sel);

    x7seg_hexdec u_hexdec (
        .i_nib (w_nib),
        .i_dp  (w_dp),
        .o_seg (w_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_sh_data <= '0;
            r_sh_dp   <= '0;
            r_sh_mask <= '0;
            r_an      <= AN_OFF;
            r_seg     <= SEG_OFF;
        end else begin
            r_presc <= r_presc + DIV_W'(1);

            if (w_tick) begin
                if (r_idx == IDX_W'(NDIG - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end

            if (load) begin
                r_sh_data <= data;
                r_sh_dp   <= dp;
                r_sh_mask <= en_mask;
            end

            // The tick edge always drives the dead cycle so the old digit's
            // segments never overlap the next anode.
            if (w_tick || w_dark) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
            end else begin
                r_an  <= w_onehot ^ AN_OFF;
                r_seg <= w_pat ^ SEG_OFF;
            end
        end
    end

    assign an     = r_an;
    assign a_to_g = r_seg;

endmodule

// File: tb/tb_x7seg_scan.sv
module tb_x7seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en_mask;
    logic        blank_lz;
    logic [3:0]  an;
    logic [7:0]  a_to_g;
    logic [3:0]  an_p;
    logic [7:0]  a_to_g_p;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    x7seg_scan #(.NDIG(4), .DIV_W(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data),
        .dp       (dp),
        .en_mask  (en_mask),
        .blank_lz (blank_lz),
        .an       (an),
        .a_to_g   (a_to_g)
    );

    x7seg_scan #(.NDIG(4), .DIV_W(2), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) u_dut_pos (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data),
        .dp       (dp),
        .en_mask  (en_mask),
        .blank_lz (blank_lz),
        .an       (an_p),
        .a_to_g   (a_to_g_p)
    );

    typedef struct {
        string            name;
        logic [15:0]      data;
        logic [3:0]       dp;
        logic [3:0]       mask;
        logic             blz;
        logic [3:0]       lit;
        logic [3:0][7:0]  seg;   // active-low expected glyph per digit, [0] = digit 0
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input string nm, input logic [15:0] d, input logic [3:0] p,
                                input logic [3:0] m, input logic b, input logic [3:0] l,
                                input logic [3:0][7:0] s);
        vec_t v;
        v.name = nm; v.data = d; v.dp = p; v.mask = m; v.blz = b; v.lit = l; v.seg = s;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later. cyc counts edges since reset release.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) cyc = 0;
        else     cyc++;
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, " an"},    {4'h0, an},   8'h0F);
        chk({nm, " seg"},   a_to_g,       8'hFF);
        chk({nm, " an+"},   {4'h0, an_p}, 8'h00);
        chk({nm, " seg+"},  a_to_g_p,     8'h00);
    endtask

    // Load one vector, then check a full 16-cycle frame on both instances.
    task automatic run_frame(input vec_t v);
        int         d;
        logic [3:0] oh;
        string      nm;
        data = v.data; dp = v.dp; en_mask = v.mask; blank_lz = v.blz; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            nm = $sformatf("%s c%0d", v.name, cyc % 16);
            d  = ((cyc - 1) / 4) % 4;
            oh = 4'b0001 << d;
            if ((cyc % 4 == 0) || !v.lit[d]) begin
                chk_dark(nm);
            end else begin
                chk({nm, " an"},   {4'h0, an},   {4'h0, ~oh});
                chk({nm, " seg"},  a_to_g,       v.seg[d]);
                chk({nm, " an+"},  {4'h0, an_p}, {4'h0, oh});
                chk({nm, " seg+"}, a_to_g_p,     ~v.seg[d]);
            end
        end
    endtask

    initial begin
        vecs[0] = mk("scan",    16'h12AF, 4'h0, 4'hF, 1'b0, 4'hF, {8'hF9, 8'hA4, 8'h88, 8'h8E});
        vecs[1] = mk("lz",      16'h0040, 4'h0, 4'hF, 1'b1, 4'h3, {8'hFF, 8'hFF, 8'h99, 8'hC0});
        vecs[2] = mk("lz_dp3",  16'h0040, 4'h8, 4'hF, 1'b1, 4'hF, {8'h40, 8'hC0, 8'h99, 8'hC0});
        vecs[3] = mk("nolz",    16'h0040, 4'h0, 4'hF, 1'b0, 4'hF, {8'hC0, 8'hC0, 8'h99, 8'hC0});
        vecs[4] = mk("mask",    16'h12AF, 4'h0, 4'h5, 1'b0, 4'h5, {8'hF9, 8'hA4, 8'h88, 8'h8E});
        vecs[5] = mk("dp0",     16'h12AF, 4'h1, 4'hF, 1'b0, 4'hF, {8'hF9, 8'hA4, 8'h88, 8'h0E});
        vecs[6] = mk("allzero", 16'h0000, 4'h0, 4'hF, 1'b1, 4'h1, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
        vecs[7] = mk("hex",     16'hE5C3, 4'h0, 4'hF, 1'b0, 4'hF, {8'h86, 8'h92, 8'hC6, 8'hB0});

        rst = 1'b1; load = 1'b0; data = '0; dp = '0; en_mask = '0; blank_lz = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk_dark("reset");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk_dark("post_reset_dark");

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Mid-slot load, then a load on the edge just before a tick.
        run_frame(vecs[0]);
        while (cyc % 16 != 1) step();
        chk("mid pre an",  {4'h0, an}, 8'h0E);
        chk("mid pre seg", a_to_g,     8'h8E);
        data = 16'h0008; dp = 4'h0; en_mask = 4'hF; blank_lz = 1'b0; load = 1'b1;
        step();
        chk("mid load edge seg", a_to_g, 8'h8E);
        data = 16'h12AF;
        step();
        chk("mid after an",  {4'h0, an}, 8'h0E);
        chk("mid after seg", a_to_g,     8'h80);
        load = 1'b0;
        step();
        chk("pretick dead an",  {4'h0, an}, 8'h0F);
        chk("pretick dead seg", a_to_g,     8'hFF);
        step();
        chk("pretick next an",  {4'h0, an}, 8'h0D);
        chk("pretick next seg", a_to_g,     8'h88);

        // Reset while digit 2 is lit.
        while (cyc % 16 != 9) step();
        chk("d2 lit an",  {4'h0, an}, 8'h0B);
        chk("d2 lit seg", a_to_g,     8'hA4);
        rst = 1'b1;
        step();
        chk_dark("midscan_rst");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_dark($sformatf("after_rst c%0d", cyc));
        end
        run_frame(vecs[0]);

        // Active-high polarity instance showing digit 0 "F".
        while (cyc % 16 != 1) step();
        chk("pos an",  {4'h0, an_p}, 8'h01);
        chk("pos seg", a_to_g_p,     8'h71);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/x7seg_scan.md
# x7seg_scan

Multiplexed multi-digit seven-segment display driver with per-digit decimal point, digit enable mask and optional leading-zero blanking. It captures a display word into a shadow register on a load strobe, then time-multiplexes the digits onto one shared 8-bit segment bus plus NDIG anode lines. A one-cycle dead time separates consecutive digits to suppress ghosting. It sits between the measurement/datapath logic and the board display pins, replacing per-digit static decoding.

## Interface
- NDIG, 4: number of digits, 1..8.
- DIV_W, 16: refresh prescaler width, at least 2; digit slot = 2^DIV_W cycles.
- SEG_ACT_LOW, 1: 1 = segment/dp outputs active-low.
- AN_ACT_LOW, 1: 1 = anode outputs active-low.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture data/dp/en_mask into shadow this edge.
- data  in  4*NDIG  hex nibbles; nibble i = data[4i+3:4i], digit 0 least significant.
- dp  in  NDIG  decimal point per digit, 1 = lit.
- en_mask  in  NDIG  1 = digit enabled.
- blank_lz  in  1  leading-zero blanking enable (live, not shadowed).
- an  out  NDIG  digit select, one-hot when active.
- a_to_g  out  8  bit7 = dp, bit6..0 = g,f,e,d,c,b,a.

## Operation
- Shadow registers sh_data, sh_dp, sh_mask load when load=1; reset clears all to 0, so every digit is dark until first load.
- Prescaler presc (DIV_W bits) free-runs; tick = (presc == all ones), presc wraps to 0.
- Digit index idx (max(1,clog2(NDIG)) bits): on tick, idx <= idx+1, wrapping NDIG-1 -> 0. NDIG=1: idx stays 0.
- Active-high segment patterns 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; bit7 = sh_dp[idx].
- Leading zero: digit i is leading zero if i>0 and, for all j>=i, nibble j == 0 and sh_dp[j] == 0. A digit is dark if sh_mask[i]==0, or blank_lz==1 and it is a leading zero.
- Dark digit: its anode is inactive and all segments, including dp, are off.
- Polarity is applied last: pattern XOR {8{SEG_ACT_LOW}}, one-hot XOR {NDIG{AN_ACT_LOW}}.

## Timing
- Reset: presc=0, idx=0. Outputs are registered off: an = all inactive (4'b1111 default), a_to_g = all off (8'hFF default).
- Outputs are registered. On the tick edge, outputs load dead time (all off). On every other edge, outputs load the decode of the current idx and shadow.
- Per slot: 1 dead cycle, then 2^DIV_W-1 lit cycles. First slot after reset: 1 off cycle (reset edge), then digit 0 lit.
- A load at edge k is visible on the outputs at edge k+1 (mid-slot update allowed), unless edge k+1 is a tick edge.
- rst has priority over load and tick. rst mid-scan returns idx to 0, clears the shadow and forces outputs off on that edge.
- load asserted every cycle is legal and tracks the inputs with 1-cycle latency.
- Changes to blank_lz take effect on the next non-tick edge.

## Structure
- Shared package/header x7seg_defs: 16-entry hex segment constant table, bit positions (SEG_DP=7), and polarity default values.
- Sub-module x7seg_hexdec: combinational nibble+dp -> active-high 8-bit pattern, reused by other display blocks.
- Top x7seg_scan holds the prescaler, idx, shadow, leading-zero logic and output registers.

## Test plan
All scenarios use DIV_W=2 (4-cycle slot) and NDIG=4 with default polarities.
- Reset: hold rst for 3 cycles -> an=4'b1111, a_to_g=8'hFF. After release, no digit lights, because the shadow is all zero.
- Scan: load data=16'h12AF, dp=0, en_mask=4'hF, blank_lz=0 -> digits show in order:
  - digit 0: an=1110, a_to_g=8h8E
  - digit 1: an=1101, 88
  - digit 2: an=1011, A4
  - digit 3: an=0111, F9
  Check the 1 dead cycle (1111/FF) at every tick and the 0 -> 3 -> 0 wrap.
- Leading zeros: data=16'h0040, blank_lz=1 -> digits 3 and 2 dark, digit 1 = 8'h99, digit 0 = 8'hC0. Add dp[3]=1 -> digit 3 = 8'h40 and digits 2,1,0 are shown.
- Mask: en_mask=4'b0101 with the scan data -> slots 1 and 3 stay an=1111, a_to_g=FF.
- Mid-slot load: load 16'h0008 during the second lit cycle of digit 0 -> the next cycle shows 8'h80. Load on the cycle before a tick -> the dead cycle is unaffected.
- Reset mid-scan: assert rst while digit 2 is lit -> the next edge gives 1111/FF, idx=0, and the display stays dark until a new load. With SEG_ACT_LOW=0 and AN_ACT_LOW=0, digit 0 "F" gives an=0001, a_to_g=8'h71.
